// File: rtl/rtc_calendar.sv
`default_nettype none
// ============================================================================
// Module   : rtc_calendar
// Purpose  : Time-of-day and Gregorian calendar counter advanced by a 1 Hz
//            enable, with a per-field increment setup mode.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_calendar #(
    parameter int YEAR_BASE = 2000,
    parameter int YEAR_SPAN = 100,
    parameter int RST_DOW   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_set_en,
    input  logic [2:0] i_set_sel,
    input  logic       i_set_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hr,
    output logic [4:0] o_date,
    output logic [3:0] o_month,
    output logic [6:0] o_year,
    output logic [2:0] o_dow,
    output logic [5:0] o_hit
);

    localparam logic [6:0] c_YEAR_MAX = 7'(YEAR_SPAN - 1);
    localparam logic [2:0] c_RST_DOW  = 3'(RST_DOW);

    localparam logic [2:0] c_SEL_SEC   = 3'd0;
    localparam logic [2:0] c_SEL_MIN   = 3'd1;
    localparam logic [2:0] c_SEL_HR    = 3'd2;
    localparam logic [2:0] c_SEL_DATE  = 3'd3;
    localparam logic [2:0] c_SEL_MONTH = 3'd4;
    localparam logic [2:0] c_SEL_YEAR  = 3'd5;
    localparam logic [2:0] c_SEL_DOW   = 3'd6;

    logic [5:0] r_sec, r_min, w_sec, w_min, r_hit, w_hit;
    logic [4:0] r_hr, r_date, w_hr, w_date, w_dim;
    logic [3:0] r_month, w_month;
    logic [6:0] r_year, w_year;
    logic [2:0] r_dow, w_dow;

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [6:0] year);
        logic [15:0] y;
        logic        leap;
        y    = 16'(YEAR_BASE) + {9'd0, year};
        leap = (y[1:0] == 2'b00) && (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
        case (month)
            4'd2:                   return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] clamp_date(input logic [4:0] date, input logic [4:0] dim);
        return (date > dim) ? dim : date;
    endfunction

    always_comb begin
        w_sec   = r_sec;
        w_min   = r_min;
        w_hr    = r_hr;
        w_date  = r_date;
        w_month = r_month;
        w_year  = r_year;
        w_dow   = r_dow;
        w_hit   = 6'd0;
        w_dim   = days_in_month(r_month, r_year);

        if (i_set_en) begin
            // Setup edits wrap inside their own field; month/year edits re-clamp the date.
            if (i_set_inc) begin
                case (i_set_sel)
                    c_SEL_SEC:   w_sec  = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                    c_SEL_MIN:   w_min  = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                    c_SEL_HR:    w_hr   = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
                    c_SEL_DATE:  w_date = (r_date == w_dim) ? 5'd1 : r_date + 5'd1;
                    c_SEL_MONTH: begin
                        w_month = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
                        w_date  = clamp_date(r_date, days_in_month(w_month, r_year));
                    end
                    c_SEL_YEAR: begin
                        w_year = (r_year == c_YEAR_MAX) ? 7'd0 : r_year + 7'd1;
                        w_date = clamp_date(r_date, days_in_month(r_month, w_year));
                    end
                    c_SEL_DOW:   w_dow  = (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
                    default: ;
                endcase
            end
        end else if (i_tick) begin
            if (r_sec != 6'd59) begin
                w_sec = r_sec + 6'd1;
            end else begin
                w_sec    = 6'd0;
                w_hit[0] = 1'b1;
                if (r_min != 6'd59) begin
                    w_min = r_min + 6'd1;
                end else begin
                    w_min    = 6'd0;
                    w_hit[1] = 1'b1;
                    if (r_hr != 5'd23) begin
                        w_hr = r_hr + 5'd1;
                    end else begin
                        w_hr     = 5'd0;
                        w_hit[2] = 1'b1;
                        w_dow    = (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
                        if (r_date != w_dim) begin
                            w_date = r_date + 5'd1;
                        end else begin
                            // Date restarts at 1, so a month/year carry never needs a clamp.
                            w_date   = 5'd1;
                            w_hit[3] = 1'b1;
                            if (r_month != 4'd12) begin
                                w_month = r_month + 4'd1;
                            end else begin
                                w_month  = 4'd1;
                                w_hit[4] = 1'b1;
                                if (r_year != c_YEAR_MAX) begin
                                    w_year = r_year + 7'd1;
                                end else begin
                                    w_year   = 7'd0;
                                    w_hit[5] = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec   <= 6'd0;
            r_min   <= 6'd0;
            r_hr    <= 5'd0;
            r_date  <= 5'd1;
            r_month <= 4'd1;
            r_year  <= 7'd0;
            r_dow   <= c_RST_DOW;
            r_hit   <= 6'd0;
        end else begin
            r_sec   <= w_sec;
            r_min   <= w_min;
            r_hr    <= w_hr;
            r_date  <= w_date;
            r_month <= w_month;
            r_year  <= w_year;
            r_dow   <= w_dow;
            r_hit   <= w_hit;
        end
    end

    assign o_sec   = r_sec;
    assign o_min   = r_min;
    assign o_hr    = r_hr;
    assign o_date  = r_date;
    assign o_month = r_month;
    assign o_year  = r_year;
    assign o_dow   = r_dow;
    assign o_hit   = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_rtc_calendar.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_calendar
// Purpose  : Self-checking bench for rtc_calendar using a day-count calendar model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_calendar;

    localparam int SPAN = 128;
    localparam int BASE = 2000;
    localparam int RDOW = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       set_en = 1'b0;
    logic [2:0] set_sel = 3'd0;
    logic       set_inc = 1'b0;
    logic [5:0] o_sec, o_min, o_hit;
    logic [4:0] o_hr, o_date;
    logic [3:0] o_month;
    logic [6:0] o_year;
    logic [2:0] o_dow;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    typedef struct packed {
        int sec; int min; int hr; int date; int month; int year; int dow;
        logic [5:0] hit;
    } cal_t;

    cal_t m;

    rtc_calendar #(.YEAR_BASE(BASE), .YEAR_SPAN(SPAN), .RST_DOW(RDOW)) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_set_en(set_en),
        .i_set_sel(set_sel), .i_set_inc(set_inc),
        .o_sec(o_sec), .o_min(o_min), .o_hr(o_hr), .o_date(o_date),
        .o_month(o_month), .o_year(o_year), .o_dow(o_dow), .o_hit(o_hit)
    );

    always #5 clk = ~clk;

    function automatic bit is_leap(int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int mdays(int yoff, int mo);
        case (mo)
            2:          return is_leap(BASE + yoff) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:    return 31;
        endcase
    endfunction

    function automatic int day_index(int yoff, int mo, int d);
        int n = 0;
        for (int y = 0; y < yoff; y++) n += is_leap(BASE + y) ? 366 : 365;
        for (int k = 1; k < mo; k++) n += mdays(yoff, k);
        return n + d - 1;
    endfunction

    function automatic cal_t set_day(cal_t c, int day);
        cal_t n = c;
        int   y = 0;
        int   mo = 1;
        while (day >= (is_leap(BASE + y) ? 366 : 365)) begin
            day -= is_leap(BASE + y) ? 366 : 365;
            y++;
        end
        while (day >= mdays(y, mo)) begin
            day -= mdays(y, mo);
            mo++;
        end
        n.year = y; n.month = mo; n.date = day + 1;
        return n;
    endfunction

    function automatic cal_t reset_val();
        cal_t r;
        r.sec = 0; r.min = 0; r.hr = 0; r.date = 1; r.month = 1; r.year = 0;
        r.dow = RDOW; r.hit = 6'd0;
        return r;
    endfunction

    // Run mode treats time as (absolute day, second-of-day); wraps are then whichever fields went down.
    function automatic cal_t model_step(cal_t c, logic en, logic tk, logic inc, logic [2:0] sel);
        cal_t n = c;
        int   sod, day;
        n.hit = 6'd0;
        if (en) begin
            if (inc) begin
                case (sel)
                    3'd0: n.sec = (c.sec + 1) % 60;
                    3'd1: n.min = (c.min + 1) % 60;
                    3'd2: n.hr  = (c.hr + 1) % 24;
                    3'd3: n.date = (c.date == mdays(c.year, c.month)) ? 1 : c.date + 1;
                    3'd4: begin
                        n.month = c.month % 12 + 1;
                        if (c.date > mdays(c.year, n.month)) n.date = mdays(c.year, n.month);
                    end
                    3'd5: begin
                        n.year = (c.year + 1) % SPAN;
                        if (c.date > mdays(n.year, c.month)) n.date = mdays(n.year, c.month);
                    end
                    3'd6: n.dow = (c.dow + 1) % 7;
                    default: ;
                endcase
            end
        end else if (tk) begin
            sod = c.hr * 3600 + c.min * 60 + c.sec + 1;
            day = day_index(c.year, c.month, c.date);
            if (sod == 86400) begin
                sod   = 0;
                day   = (day + 1) % day_index(SPAN, 1, 1);
                n.dow = (c.dow + 1) % 7;
            end
            n.hr = sod / 3600; n.min = (sod / 60) % 60; n.sec = sod % 60;
            n = set_day(n, day);
            n.hit = {n.year < c.year, n.month < c.month, n.date < c.date,
                     n.hr < c.hr, n.min < c.min, n.sec < c.sec};
        end
        return n;
    endfunction

    function automatic logic [63:0] pack(cal_t c);
        return {22'd0, 6'(c.sec), 6'(c.min), 5'(c.hr), 5'(c.date), 4'(c.month),
                7'(c.year), 3'(c.dow), c.hit};
    endfunction

    function automatic int field(cal_t c, logic [2:0] sel);
        case (sel)
            3'd0: return c.sec;   3'd1: return c.min;   3'd2: return c.hr;
            3'd3: return c.date;  3'd4: return c.month; 3'd5: return c.year;
            default: return c.dow;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= reset_val();
        else        m <= model_step(m, set_en, tick, set_inc, set_sel);
    end

    always @(negedge clk) begin
        if (run_cmp && rst_n)
            check("cycle", {22'd0, o_sec, o_min, o_hr, o_date, o_month, o_year, o_dow, o_hit}, pack(m));
    end

    task automatic pulse(logic [2:0] sel);
        @(negedge clk);
        set_en = 1'b1; set_sel = sel; set_inc = 1'b1;
        @(negedge clk);
        set_inc = 1'b0;
    endtask

    task automatic fld(logic [2:0] sel, int target);
        int n = 0;
        while (field(m, sel) != target && n < 300) begin
            pulse(sel);
            n++;
        end
        check("goto_reach", 64'(field(m, sel)), 64'(target));
    endtask

    task automatic goto(int yr, int mo, int d, int h, int mi, int s, int dw);
        fld(3'd5, yr); fld(3'd4, mo); fld(3'd3, d);
        fld(3'd2, h);  fld(3'd1, mi); fld(3'd0, s);
        if (dw >= 0) fld(3'd6, dw);
    endtask

    task automatic tick_once(logic en);
        @(negedge clk);
        set_en = en; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    localparam logic [63:0] RST_VEC = {22'd0, 6'd0, 6'd0, 5'd0, 5'd1, 4'd1, 7'd0, 3'd6, 6'd0};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 check("reset_start", {22'd0, o_sec, o_min, o_hr, o_date, o_month, o_year, o_dow, o_hit}, RST_VEC);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        run_cmp = 1'b1;

        // Leap day, then leap day into March
        goto(0, 2, 28, 23, 59, 59, 1);
        tick_once(1'b0);
        check("leap_date", {o_month, o_date}, {4'd2, 5'd29});
        check("leap_time", {o_hr, o_min, o_sec}, 17'd0);
        check("leap_dow", 64'(o_dow), 64'd2);
        check("leap_hit", 64'(o_hit), 64'b000111);
        @(negedge clk);
        check("hit_one_cycle", 64'(o_hit), 64'd0);
        goto(0, 2, 29, 23, 59, 59, 2);
        tick_once(1'b0);
        check("leap_to_mar", {o_month, o_date}, {4'd3, 5'd1});
        check("leap_mar_hit", 64'(o_hit), 64'b001111);

        // 2100 is not a leap year
        goto(100, 2, 28, 23, 59, 59, 0);
        tick_once(1'b0);
        check("century", {o_year, o_month, o_date}, {7'd100, 4'd3, 5'd1});
        check("century_hit", 64'(o_hit), 64'b001111);

        // Year wrap at the end of the span
        goto(SPAN - 1, 12, 31, 23, 59, 59, 6);
        tick_once(1'b0);
        check("ywrap_date", {o_year, o_month, o_date}, {7'd0, 4'd1, 5'd1});
        check("ywrap_time", {o_hr, o_min, o_sec}, 17'd0);
        check("ywrap_dow", 64'(o_dow), 64'd0);
        check("ywrap_hit", 64'(o_hit), 64'b111111);

        // Setup clamp on month and year edits; ticks dropped in setup
        goto(0, 1, 31, 0, 0, 0, -1);
        pulse(3'd4);
        check("clamp_feb_leap", {o_month, o_date}, {4'd2, 5'd29});
        pulse(3'd5);
        check("clamp_year", {o_year, o_date}, {7'd1, 5'd28});
        repeat (3) tick_once(1'b1);
        check("setup_tick_drop", {o_year, o_month, o_date, o_sec, o_hit}, {7'd1, 4'd2, 5'd28, 6'd0, 6'd0});

        // No carry from a setup increment; select 7 is a no-op even with a tick
        goto(1, 2, 28, 0, 17, 59, -1);
        pulse(3'd0);
        check("nocarry", {o_min, o_sec, o_hit}, {6'd17, 6'd0, 6'd0});
        @(negedge clk);
        set_sel = 3'd7; set_inc = 1'b1; tick = 1'b1;
        @(negedge clk);
        set_inc = 1'b0; tick = 1'b0;
        check("sel7_tick", {o_min, o_sec, o_date, o_hit}, {6'd17, 6'd0, 5'd28, 6'd0});

        // Continuous run across a year boundary with ignored inc pulses
        goto(1, 12, 31, 23, 58, 30, 3);
        @(negedge clk);
        set_en = 1'b0; tick = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_inc = 1'($urandom_range(0, 1));
            set_sel = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        tick = 1'b0; set_inc = 1'b0;
        check("burst_end", {o_year, o_month, o_date, o_hr, o_min, o_sec},
              {7'd2, 4'd1, 5'd1, 5'd0, 6'd0, 6'd10});
        check("burst_dow", 64'(o_dow), 64'd4);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            tick = (i % 3 == 0);
        end
        tick = 1'b0;

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_async", {22'd0, o_sec, o_min, o_hr, o_date, o_month, o_year, o_dow, o_hit}, RST_VEC);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
